// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch front end.
//   DEFAULT_XLEN     - default address/data width
//   DEFAULT_RESET_PC - default PC loaded on reset
//   NOP              - canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t    - {pc, instr} pair held in the decode-side buffer
package fetch_pkg;
  localparam int                DEFAULT_XLEN     = 32;
  localparam logic [31:0]       DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0]       NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with synchronous flush.
//   clk, rst_n        - clock, asynchronous active-low reset
//   flush             - drop all entries this cycle (wins over push/pop)
//   push, push_data   - write an entry; caller guarantees !full
//   pop               - retire the head entry; caller guarantees !empty
//   head              - current head entry (combinational read)
//   count, empty, full- occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   clk, rst_n                        - clock, asynchronous active-low reset
//   redirect_valid, redirect_target   - branch/jump redirect from execute
//   imem_req_valid/ready/addr         - in-order word fetch requests
//   imem_rsp_valid, imem_rsp_data     - in-order responses, no backpressure
//   if_valid/ready, if_pc, if_pc_plus4, if_instr - decode-side stream
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready in the same direction, and the
// payload is only meaningful while valid is high.
//
// Credits: requests in flight plus entries buffered for decode never exceed
// DEPTH, so the output FIFO always has room for every response.
// Redirect: all work issued before the redirect is wrong-path. Buffered
// entries are flushed at once; responses still in flight are counted in
// drop_cnt and discarded as they arrive (their tags still pop in order).
module fetch_unit import fetch_pkg::*; #(
  parameter int               XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC,
  parameter int               DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic            active;     // low during reset and its first cycle out
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   out_count;
  logic [CW:0]     used;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_pop;
  logic            rsp_keep;
  logic            out_pop;
  logic            tag_empty, tag_full;
  logic            out_empty, out_full;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    out_entry;
  fetch_entry_t    out_head;

  assign used      = {1'b0, inflight} + {1'b0, out_count};
  assign credit_ok = (used < (CW+1)'(DEPTH));

  assign imem_req_valid = active && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A stray response with no tag is ignored entirely.
  assign rsp_pop  = imem_rsp_valid && !tag_empty;
  assign rsp_keep = rsp_pop && !redirect_valid && (drop_cnt == '0);

  assign out_entry.pc    = tag_pc;
  assign out_entry.instr = imem_rsp_data;

  assign if_valid    = !out_empty && !redirect_valid;
  assign out_pop     = if_valid && if_ready;
  assign if_pc       = out_empty ? '0 : out_head.pc;
  assign if_pc_plus4 = out_empty ? '0 : out_head.pc + XLEN'(4);
  assign if_instr    = out_empty ? '0 : out_head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      pc     <= RESET_PC;
    end else begin
      active <= 1'b1;
      // Masking keeps every target bit in the expression; the low two
      // bits are forced to zero for word alignment.
      if (redirect_valid) pc <= redirect_target & ~XLEN'(3);
      else if (req_fire)  pc <= pc + XLEN'(4);
    end
  end

  // Recomputed on every redirect so back-to-back redirects cover every
  // response still outstanding, including ones already marked stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop_cnt <= '0;
    else if (redirect_valid)              drop_cnt <= inflight - CW'(rsp_pop);
    else if (rsp_pop && drop_cnt != '0)   drop_cnt <= drop_cnt - CW'(1);
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_pop),
    .head      (tag_pc),
    .count     (inflight),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (out_entry),
    .pop       (out_pop),
    .head      (out_head),
    .count     (out_count),
    .empty     (out_empty),
    .full      (out_full)
  );

  rsp_needs_tag: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !tag_empty);
  tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  out_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !out_full);
endmodule
